// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared constants and FSM encoding for the 4-slot TDM demux
// Revision    : 1.0 - initial release
// ============================================================================

package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_ctr
// Description : Frame-alignment FSM and slot counter with sync realignment
// Revision    : 1.0 - initial release
// ============================================================================

module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              sync,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err,
    output logic              wr_en,
    output logic [SLOT_W-1:0] wr_idx,
    output logic              complete
);

    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] slot_nxt;
    logic              sync_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            slot     <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            sync_err <= sync_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        slot_nxt     = slot;
        sync_err_nxt = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = slot;
        complete     = 1'b0;
        case (state)
            HUNT: begin
                if (in_valid && sync) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    slot_nxt  = SLOT_W'(1);
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    // A sync away from slot 0 restarts the frame; the stale
                    // partial slots get overwritten before the next completion.
                    if (sync && (slot != '0)) begin
                        sync_err_nxt = 1'b1;
                        wr_idx       = '0;
                        slot_nxt     = SLOT_W'(1);
                    end else begin
                        slot_nxt = slot + SLOT_W'(1);
                        complete = (slot == SLOT_W'(NUM_SLOTS - 1));
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    assign locked = (state == RUN);

endmodule

`default_nettype wire

// File: rtl/tdm_demux_14.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_14
// Description : 4-slot TDM demultiplexer with shadow frame and ready/valid out
// Revision    : 1.0 - initial release
// ============================================================================

module tdm_demux_14
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           din,
    input  logic                   in_valid,
    input  logic                   sync,
    output logic [NUM_SLOTS*W-1:0] frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLOT_W-1:0]      slot,
    output logic                   locked,
    output logic                   sync_err,
    output logic                   overflow
);

    logic                   wr_en;
    logic [SLOT_W-1:0]      wr_idx;
    logic                   complete;
    logic                   take;
    logic [NUM_SLOTS*W-1:0] new_frame;

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .sync     (sync),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .complete (complete)
    );

    // The last slot never needs a shadow: it is taken straight from din.
    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS - 1; k++) begin : g_shadow
            logic [W-1:0] q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (wr_en && (wr_idx == SLOT_W'(k))) begin
                    q <= din;
                end
            end
            assign new_frame[k*W +: W] = q;
        end
    endgenerate

    assign new_frame[(NUM_SLOTS-1)*W +: W] = din;
    assign take = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (complete) begin
                if (!out_valid || take) begin
                    frame     <= new_frame;
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
